// File: rtl/rs_issue_scheduler.sv
// Round-robin issue of ready reservation stations into a registered ALU stage,
// plus combinational lowest-free station allocation for dispatch.
module rs_issue_scheduler #(
   parameter int N_RS      = 4,
   parameter int XLEN      = 32,
   parameter int TAG_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [N_RS-1:0]           rs_busy,
   input  logic [N_RS-1:0]           rs_ready,
   input  logic [N_RS*TAG_WIDTH-1:0] rs_tag,
   input  logic [N_RS*3-1:0]         rs_alu_op,
   input  logic [N_RS*XLEN-1:0]      rs_op1,
   input  logic [N_RS*XLEN-1:0]      rs_op2,
   input  logic                      alloc_req,
   output logic [N_RS-1:0]           alloc_onehot,
   output logic                      alloc_stall,
   output logic [N_RS-1:0]           issue_clear,
   input  logic                      fu_ready,
   output logic                      fu_valid,
   output logic [TAG_WIDTH-1:0]      fu_tag,
   output logic [2:0]                fu_alu_op,
   output logic [XLEN-1:0]           fu_op1,
   output logic [XLEN-1:0]           fu_op2
);

   localparam int PW = (N_RS > 1) ? $clog2(N_RS) : 1;

   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   sel;
   logic [PW-1:0]   idx;
   logic            found;
   logic            free_found;
   logic            load;
   logic            do_issue;
   logic [N_RS-1:0] cand;

   assign cand     = rs_busy & rs_ready;
   assign load     = !fu_valid || fu_ready;
   assign do_issue = load && !flush && !reset && found;

   // Search upward from rr_ptr; PW-bit addition gives the wrap for free.
   always_comb begin
      sel   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N_RS; i++) begin
         idx = rr_ptr + PW'(i);
         if (!found && cand[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   assign issue_clear = do_issue ? (N_RS'(1) << sel) : '0;

   always_comb begin
      alloc_onehot = '0;
      free_found   = 1'b0;
      for (int i = 0; i < N_RS; i++) begin
         if (!free_found && !rs_busy[i]) begin
            alloc_onehot[i] = alloc_req;
            free_found      = 1'b1;
         end
      end
   end

   assign alloc_stall = alloc_req && (&rs_busy);

   always_ff @(posedge clk) begin
      if (reset) begin
         fu_valid  <= 1'b0;
         fu_tag    <= '0;
         fu_alu_op <= '0;
         fu_op1    <= '0;
         fu_op2    <= '0;
         rr_ptr    <= '0;
      end else if (flush) begin
         fu_valid <= 1'b0;
      end else if (do_issue) begin
         fu_valid  <= 1'b1;
         fu_tag    <= rs_tag[sel*TAG_WIDTH +: TAG_WIDTH];
         fu_alu_op <= rs_alu_op[sel*3 +: 3];
         fu_op1    <= rs_op1[sel*XLEN +: XLEN];
         fu_op2    <= rs_op2[sel*XLEN +: XLEN];
         rr_ptr    <= sel + PW'(1);
      end else if (fu_ready) begin
         fu_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed scenarios for rs_issue_scheduler; issued entries are checked through a
// scoreboard queue filled when an issue is expected and drained at the output stage.
module tb_rs_issue_scheduler;
   localparam int N  = 4;
   localparam int XL = 32;
   localparam int TW = 32;

   logic            clk = 1'b0;
   logic            reset, flush, alloc_req, fu_ready;
   logic [N-1:0]    rs_busy, rs_ready, alloc_onehot, issue_clear;
   logic [N*TW-1:0] rs_tag;
   logic [N*3-1:0]  rs_alu_op;
   logic [N*XL-1:0] rs_op1, rs_op2;
   logic            alloc_stall, fu_valid;
   logic [TW-1:0]   fu_tag;
   logic [2:0]      fu_alu_op;
   logic [XL-1:0]   fu_op1, fu_op2;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [2:0]    op;
      logic [XL-1:0] a;
      logic [XL-1:0] b;
   } exp_t;

   exp_t          q[$];
   exp_t          e;
   logic [TW-1:0] tags[N];
   int            vectors = 0;
   int            miscompares = 0;

   rs_issue_scheduler #(.N_RS(N), .XLEN(XL), .TAG_WIDTH(TW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .rs_busy(rs_busy), .rs_ready(rs_ready), .rs_tag(rs_tag),
      .rs_alu_op(rs_alu_op), .rs_op1(rs_op1), .rs_op2(rs_op2),
      .alloc_req(alloc_req), .alloc_onehot(alloc_onehot), .alloc_stall(alloc_stall),
      .issue_clear(issue_clear), .fu_ready(fu_ready), .fu_valid(fu_valid),
      .fu_tag(fu_tag), .fu_alu_op(fu_alu_op), .fu_op1(fu_op1), .fu_op2(fu_op2)
   );

   always #5 clk = ~clk;

   function automatic exp_t fields(int i);
      exp_t r;
      r.tag = tags[i];
      r.op  = 3'(i + 1);
      r.a   = 32'h1000 + 32'(i);
      r.b   = 32'h2000_0000 ^ tags[i];
      return r;
   endfunction

   task automatic set_station(int i, logic [TW-1:0] t);
      exp_t r;
      tags[i] = t;
      r = fields(i);
      rs_tag[i*TW +: TW]  = r.tag;
      rs_alu_op[i*3 +: 3] = r.op;
      rs_op1[i*XL +: XL]  = r.a;
      rs_op2[i*XL +: XL]  = r.b;
   endtask

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; alloc_req = 1'b0; fu_ready = 1'b0;
      rs_busy = '0; rs_ready = '0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) set_station(i, 32'(100 + i));
      reset = 1'b1; flush = 1'b0; alloc_req = 1'b0; fu_ready = 1'b1;
      rs_busy = 4'b1111; rs_ready = 4'b1111;
      #1;
      vectors++;
      if (issue_clear !== 4'b0000) begin
         miscompares++; $display("FAIL reset_clear: got %b want 0000", issue_clear);
      end
      @(posedge clk); #1;
      vectors++;
      if ({fu_valid, fu_tag, fu_alu_op, fu_op1, fu_op2} !== '0) begin
         miscompares++;
         $display("FAIL reset_regs: got valid=%b tag=%h op=%h op1=%h op2=%h want all 0",
                  fu_valid, fu_tag, fu_alu_op, fu_op1, fu_op2);
      end
      reset = 1'b0; rs_busy = '0; rs_ready = '0;
   endtask

   task automatic test_single_issue();
      do_reset();
      set_station(2, 32'd7);
      rs_busy = 4'b0100; rs_ready = 4'b0100; fu_ready = 1'b1;
      #1;
      vectors++;
      if (issue_clear !== 4'b0100) begin
         miscompares++; $display("FAIL single_clear: got %b want 0100", issue_clear);
      end
      q.push_back(fields(2));
      @(posedge clk); #1;
      rs_busy = 4'b1001; rs_ready = 4'b1001;
      e = q.pop_front();
      vectors++;
      if (!fu_valid || {fu_tag, fu_alu_op, fu_op1, fu_op2} !== e) begin
         miscompares++;
         $display("FAIL single_out: got valid=%b tag=%0d want valid=1 tag=%0d", fu_valid, fu_tag, e.tag);
      end
      #1;
      // rr_ptr should now be 3, so station 3 beats station 0
      vectors++;
      if (issue_clear !== 4'b1000) begin
         miscompares++; $display("FAIL single_rrptr: got %b want 1000", issue_clear);
      end
      q.push_back(fields(3));
      @(posedge clk); #1;
      rs_busy = '0; rs_ready = '0;
      e = q.pop_front();
      vectors++;
      if (!fu_valid || fu_tag !== e.tag) begin
         miscompares++; $display("FAIL single_out2: got tag=%0d want %0d", fu_tag, e.tag);
      end
      @(posedge clk); #1;
      vectors++;
      if (fu_valid !== 1'b0) begin
         miscompares++; $display("FAIL single_drain: got valid=%b want 0", fu_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] want;
      do_reset();
      for (int i = 0; i < N; i++) set_station(i, 32'(100 + i));
      rs_busy = 4'b1111; rs_ready = 4'b1111; fu_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         want = 4'b0001 << (k % N);
         vectors++;
         if (issue_clear !== want) begin
            miscompares++; $display("FAIL rr_clear[%0d]: got %b want %b", k, issue_clear, want);
         end
         q.push_back(fields(k % N));
         @(posedge clk); #1;
         e = q.pop_front();
         vectors++;
         if (!fu_valid || {fu_tag, fu_alu_op, fu_op1, fu_op2} !== e) begin
            miscompares++;
            $display("FAIL rr_out[%0d]: got valid=%b tag=%0d want tag=%0d", k, fu_valid, fu_tag, e.tag);
         end
      end
      rs_busy = '0; rs_ready = '0;
   endtask

   task automatic test_hold();
      exp_t held;
      do_reset();
      for (int i = 0; i < N; i++) set_station(i, 32'(200 + i));
      rs_busy = 4'b0010; rs_ready = 4'b0010; fu_ready = 1'b1;
      #1;
      vectors++;
      if (issue_clear !== 4'b0010) begin
         miscompares++; $display("FAIL hold_clear1: got %b want 0010", issue_clear);
      end
      q.push_back(fields(1));
      @(posedge clk); #1;
      rs_busy = 4'b1000; rs_ready = 4'b1000; fu_ready = 1'b0;
      held = q.pop_front();
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if (issue_clear !== 4'b0000) begin
            miscompares++; $display("FAIL hold_clear[%0d]: got %b want 0000", c, issue_clear);
         end
         @(posedge clk); #1;
         vectors++;
         if (!fu_valid || {fu_tag, fu_alu_op, fu_op1, fu_op2} !== held) begin
            miscompares++;
            $display("FAIL hold_stable[%0d]: got valid=%b tag=%0d want tag=%0d", c, fu_valid, fu_tag, held.tag);
         end
      end
      fu_ready = 1'b1;
      #1;
      vectors++;
      if (issue_clear !== 4'b1000) begin
         miscompares++; $display("FAIL hold_release: got %b want 1000", issue_clear);
      end
      q.push_back(fields(3));
      @(posedge clk); #1;
      rs_busy = '0; rs_ready = '0;
      e = q.pop_front();
      vectors++;
      if (!fu_valid || {fu_tag, fu_alu_op, fu_op1, fu_op2} !== e) begin
         miscompares++; $display("FAIL hold_out: got tag=%0d want %0d", fu_tag, e.tag);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < N; i++) set_station(i, 32'(300 + i));
      rs_busy = 4'b0010; rs_ready = 4'b0010; fu_ready = 1'b1;
      q.push_back(fields(1));
      @(posedge clk); #1;
      e = q.pop_front();
      vectors++;
      if (!fu_valid || fu_tag !== e.tag) begin
         miscompares++; $display("FAIL flush_pre: got valid=%b tag=%0d want tag=%0d", fu_valid, fu_tag, e.tag);
      end
      rs_busy = 4'b0101; rs_ready = 4'b0101; flush = 1'b1;
      #1;
      vectors++;
      if (issue_clear !== 4'b0000) begin
         miscompares++; $display("FAIL flush_clear: got %b want 0000", issue_clear);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      vectors++;
      if (fu_valid !== 1'b0) begin
         miscompares++; $display("FAIL flush_valid: got %b want 0", fu_valid);
      end
      #1;
      // rr_ptr still 2 after the flush, so station 2 goes first
      vectors++;
      if (issue_clear !== 4'b0100) begin
         miscompares++; $display("FAIL flush_rrptr: got %b want 0100", issue_clear);
      end
      q.push_back(fields(2));
      @(posedge clk); #1;
      rs_busy = 4'b0001; rs_ready = 4'b0001;
      e = q.pop_front();
      vectors++;
      if (!fu_valid || fu_tag !== e.tag) begin
         miscompares++; $display("FAIL flush_out2: got tag=%0d want %0d", fu_tag, e.tag);
      end
      #1;
      vectors++;
      if (issue_clear !== 4'b0001) begin
         miscompares++; $display("FAIL flush_st0: got %b want 0001", issue_clear);
      end
      q.push_back(fields(0));
      @(posedge clk); #1;
      rs_busy = '0; rs_ready = '0;
      e = q.pop_front();
      vectors++;
      if (!fu_valid || {fu_tag, fu_alu_op, fu_op1, fu_op2} !== e) begin
         miscompares++; $display("FAIL flush_out0: got tag=%0d want %0d", fu_tag, e.tag);
      end
   endtask

   task automatic test_alloc();
      logic [N-1:0] busy_v[7]  = '{4'b1011, 4'b1111, 4'b1011, 4'b0000, 4'b1110, 4'b0111, 4'b0001};
      logic         req_v[7]   = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b1};
      logic [N-1:0] oh_v[7]    = '{4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1000, 4'b0010};
      logic         stall_v[7] = '{1'b0,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0,    1'b0};
      do_reset();
      fu_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         rs_busy   = busy_v[k];
         rs_ready  = (k == 6) ? 4'b0001 : 4'b0000;
         alloc_req = req_v[k];
         #1;
         vectors++;
         if (alloc_onehot !== oh_v[k] || alloc_stall !== stall_v[k]) begin
            miscompares++;
            $display("FAIL alloc[%0d]: got onehot=%b stall=%b want onehot=%b stall=%b",
                     k, alloc_onehot, alloc_stall, oh_v[k], stall_v[k]);
         end
      end
      // last entry: station 0 is being cleared this cycle yet still not allocatable
      vectors++;
      if (issue_clear !== 4'b0001) begin
         miscompares++; $display("FAIL alloc_clear: got %b want 0001", issue_clear);
      end
      @(posedge clk); #1;
      rs_busy = '0; rs_ready = '0; alloc_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < N; i++) set_station(i, 32'(400 + i));
      rs_busy = 4'b0100; rs_ready = 4'b0100; fu_ready = 1'b1;
      q.push_back(fields(2));
      @(posedge clk); #1;
      e = q.pop_front();
      vectors++;
      if (!fu_valid || fu_tag !== e.tag) begin
         miscompares++; $display("FAIL rstmid_pre: got valid=%b tag=%0d want tag=%0d", fu_valid, fu_tag, e.tag);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (issue_clear !== 4'b0000) begin
         miscompares++; $display("FAIL rstmid_clear: got %b want 0000", issue_clear);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      vectors++;
      if (fu_valid !== 1'b0 || fu_tag !== '0) begin
         miscompares++; $display("FAIL rstmid_regs: got valid=%b tag=%0d want 0/0", fu_valid, fu_tag);
      end
      rs_busy = 4'b1001; rs_ready = 4'b1001;
      #1;
      vectors++;
      if (issue_clear !== 4'b0001) begin
         miscompares++; $display("FAIL rstmid_rrptr: got %b want 0001", issue_clear);
      end
      @(posedge clk); #1;
      rs_busy = '0; rs_ready = '0;
   endtask

   initial begin
      rs_tag = '0; rs_alu_op = '0; rs_op1 = '0; rs_op2 = '0;
      test_reset();
      test_single_issue();
      test_round_robin();
      test_hold();
      test_flush();
      test_alloc();
      test_reset_mid();
      vectors++;
      if (q.size() != 0) begin
         miscompares++; $display("FAIL scoreboard_left: got %0d entries want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
Shares one ALU functional unit among N_RS reservation stations and allocates free stations to newly dispatched instructions. Each cycle it picks one ready station round-robin and pulses that station's clear. The picked entry goes into a registered valid/ready output stage that feeds the ALU. It sits between the reservation station array and the ALU; the reorder buffer tag travels with the operands.

Parameters:
N_RS, 4, number of reservation stations (power of two, >=2)
XLEN, 32, operand data width
TAG_WIDTH, 32, reorder buffer tag width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
flush  input  1  squash: drop the held issue and block issue this cycle
rs_busy  input  N_RS  per-station busy flag
rs_ready  input  N_RS  per-station ready flag (both operands valid)
rs_tag  input  N_RS*TAG_WIDTH  packed ROB tags, station i at [i*TAG_WIDTH +: TAG_WIDTH]
rs_alu_op  input  N_RS*3  packed alu_op
rs_op1  input  N_RS*XLEN  packed op1 data
rs_op2  input  N_RS*XLEN  packed op2 data
alloc_req  input  1  dispatch wants a station
alloc_onehot  output  N_RS  station to enable (combinational)
alloc_stall  output  1  alloc_req and no free station
issue_clear  output  N_RS  one-hot pulse freeing the selected station
fu_ready  input  1  ALU accepts this cycle
fu_valid  output  1  output stage holds an instruction
fu_tag  output  TAG_WIDTH  held ROB tag
fu_alu_op  output  3  held alu_op
fu_op1  output  XLEN  held op1
fu_op2  output  XLEN  held op2

Behaviour:
- Reset (synchronous): fu_valid=0; fu_tag, fu_alu_op, fu_op1, fu_op2 = 0; rr_ptr=0. issue_clear=0 during the reset cycle.
- Candidate set: cand = rs_busy & rs_ready.
- Load enable: load = !fu_valid || fu_ready.
- Issue: if load && !flush && !reset && |cand:
  - Select the first set bit of cand searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1 .. N_RS-1, 0 .. rr_ptr-1).
  - issue_clear[sel]=1 in the same cycle.
  - Output regs take the station's fields next edge; fu_valid=1.
  - rr_ptr <= (sel+1) mod N_RS.
- No issue: otherwise issue_clear=0 and rr_ptr holds.
- Handshake:
  - fu_valid && fu_ready with nothing to load -> fu_valid<=0.
  - fu_valid && !fu_ready -> all output regs hold, no issue.
  - Back-to-back issue every cycle is allowed while fu_ready=1.
- Stale selection: a station cleared at edge k has rs_busy=0 from cycle k+1; no station is issued twice.
- Flush: fu_valid<=0 next edge, no issue_clear that cycle, rr_ptr unchanged. Output data regs may hold stale values.
- Allocation (combinational, independent of issue):
  - alloc_onehot = lowest-index bit of ~rs_busy when alloc_req=1, else 0.
  - alloc_stall = alloc_req && &rs_busy.
  - A station being cleared this cycle still counts as busy; it is allocatable next cycle.
- Latency: station ready at cycle k and selected -> fu_valid=1 at cycle k+1.
- Reset mid-operation: a held instruction is discarded; issue_clear is suppressed that cycle.

Test Plan:
- Reset, then rs_busy=rs_ready=4'b0100, rs_tag[2]=7, fu_ready=1 -> issue_clear=4'b0100 that cycle; next cycle fu_valid=1, fu_tag=7, rr_ptr=3.
- All four stations busy+ready continuously (re-asserted after clear), fu_ready=1 -> grant order 0,1,2,3,0; one issue_clear per cycle.
- Hold: station 1 issued; fu_ready=0 for 3 cycles while station 3 ready -> fu outputs stable, issue_clear=0. fu_ready=1 -> station 3 issues that cycle and fu_tag updates next edge.
- flush while fu_valid=1 and station 0 ready -> fu_valid=0 next cycle, issue_clear=0, rr_ptr unchanged. Station 0 issues the following cycle.
- Allocation: rs_busy=4'b1011, alloc_req=1 -> alloc_onehot=4'b0100, alloc_stall=0. rs_busy=4'b1111 -> alloc_onehot=0, alloc_stall=1. alloc_req=0 -> both 0.
- Reset asserted with fu_valid=1 and station 2 ready -> issue_clear=0, fu_valid=0, rr_ptr=0 after the edge.
